// File: rtl/ps_loader.sv
// Passive-serial configuration sequencer: kicks the nCONFIG starter, streams the bitstream
// LSB-first on dclk/data0, checks CONF_DONE and issues the initialization clocks.
module ps_loader #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned INIT_CLOCKS = 3192,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] length,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        starter_start,
  input  logic        starter_ready,
  input  logic        starter_error,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dclk,
  output logic        data0,
  input  logic        n_status,
  input  logic        conf_done
);

  localparam logic [31:0] HalfLast  = 32'(CLK_DIV - 1);
  localparam logic [31:0] CheckLast = 32'(SYNC_STAGES + 1);
  localparam logic [31:0] InitLast  = 32'(INIT_CLOCKS - 1);

  typedef enum logic [3:0] {
    StIdle, StKick, StArm, StWaitSt, StLoad, StShiftLo, StShiftHi, StCheck, StInit, StDone,
    StError
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] ns_sync_q, cd_sync_q;
  logic [31:0]            remaining_q, cnt_q, init_cnt_q;
  logic [7:0]             shreg_q;
  logic [2:0]             bit_q;
  logic                   ns_s, cd_s, ns_watch;

  // nSTATUS idles high, so its synchronizer resets high to avoid a false error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ns_sync_q <= '1;
      cd_sync_q <= '0;
    end else begin
      ns_sync_q[0] <= n_status;
      cd_sync_q[0] <= conf_done;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        ns_sync_q[i] <= ns_sync_q[i-1];
        cd_sync_q[i] <= cd_sync_q[i-1];
      end
    end
  end

  assign ns_s     = ns_sync_q[SYNC_STAGES-1];
  assign cd_s     = cd_sync_q[SYNC_STAGES-1];
  assign s_ready  = (state_q == StLoad);
  assign ns_watch = state_q inside {StLoad, StShiftLo, StShiftHi, StCheck, StInit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      starter_start <= 1'b0;
      dclk          <= 1'b0;
      data0         <= 1'b0;
      remaining_q   <= '0;
      cnt_q         <= '0;
      init_cnt_q    <= '0;
      shreg_q       <= '0;
      bit_q         <= '0;
    end else if (ns_watch && !ns_s) begin
      state_q  <= StError;
      busy     <= 1'b0;
      error    <= 1'b1;
      err_code <= 2'd3;
      dclk     <= 1'b0;
      data0    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q       <= StKick;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            starter_start <= 1'b1;
            remaining_q   <= length;
          end
        end
        StKick: begin
          starter_start <= 1'b0;
          state_q       <= StArm;
        end
        StArm: state_q <= StWaitSt;
        StWaitSt: begin
          if (starter_error) begin
            state_q  <= StError;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd1;
          end else if (starter_ready) begin
            cnt_q <= '0;
            // Zero length or an already-configured device skip straight to the check.
            if (remaining_q == '0 || cd_s) state_q <= StCheck;
            else state_q <= StLoad;
          end
        end
        StLoad: begin
          if (s_valid) begin
            shreg_q     <= s_data;
            remaining_q <= remaining_q - 32'd1;
            bit_q       <= 3'd0;
            cnt_q       <= '0;
            data0       <= s_data[0];
            state_q     <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            dclk    <= 1'b1;
            state_q <= StShiftHi;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StShiftHi: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            dclk  <= 1'b0;
            if (bit_q != 3'd7) begin
              bit_q   <= bit_q + 3'd1;
              data0   <= shreg_q[bit_q + 3'd1];
              state_q <= StShiftLo;
            end else if (remaining_q != '0 && !cd_s) begin
              state_q <= StLoad;
            end else begin
              state_q <= StCheck;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StCheck: begin
          if (cnt_q == CheckLast) begin
            cnt_q <= '0;
            if (cd_s) begin
              init_cnt_q <= '0;
              data0      <= 1'b0;
              state_q    <= StInit;
            end else begin
              state_q  <= StError;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 2'd2;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StInit: begin
          if (cnt_q == HalfLast) begin
            cnt_q <= '0;
            dclk  <= ~dclk;
            // A full period completes on each high-to-low transition.
            if (dclk) begin
              if (init_cnt_q == InitLast) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                init_cnt_q <= init_cnt_q + 32'd1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_loader.sv
// Directed/randomized bench for ps_loader with a starter model, byte source and a bit-level
// reference of the expected dclk/data0 stream.
module tb_ps_loader;
  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned INIT_CLOCKS = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          Never       = 1 << 30;

  logic        clock = 1'b0, reset;
  logic        start, busy, done, error, starter_start, starter_ready, starter_error;
  logic [31:0] length;
  logic [1:0]  err_code;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, dclk, data0, n_status, conf_done;

  ps_loader #(.CLK_DIV(CLK_DIV), .INIT_CLOCKS(INIT_CLOCKS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock(clock), .reset(reset), .start(start), .length(length), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .starter_start(starter_start),
    .starter_ready(starter_ready), .starter_error(starter_error), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .dclk(dclk), .data0(data0), .n_status(n_status),
    .conf_done(conf_done)
  );

  always #5 clock = ~clock;

  int   n_assert = 0, n_fail = 0;
  int   cyc = 0, rise_cnt = 0, sr_cnt = 0, ss_cnt = 0, stall_viol = 0;
  int   src_idx = 0, src_n = 0;
  int   cd_rise_thr = Never, cd_byte_thr = Never, ns_rise_thr = Never;
  int   stall_from = 0, stall_to = 0, stall_chk_lo = 0;
  int   st_delay = 5, st_cnt = 0;
  bit   st_fail = 1'b0, dclk_prev = 1'b0;
  logic [7:0] src_bytes [16];
  bit   rise_bits [$];

  // Observer: edges, handshakes and pulses, sampled with pre-edge values.
  always @(posedge clock) begin
    cyc++;
    if (dclk && !dclk_prev) begin
      rise_cnt++;
      rise_bits.push_back(data0);
    end
    dclk_prev = dclk;
    if (s_valid && s_ready) src_idx++;
    if (s_ready) sr_cnt++;
    if (starter_start) ss_cnt++;
    if (stall_to != 0 && cyc >= stall_chk_lo && cyc <= stall_to && dclk) stall_viol++;
  end

  // Byte source and FPGA pin model.
  always @(negedge clock) begin
    s_valid   = (src_idx < src_n) && !(cyc >= stall_from && cyc < stall_to);
    s_data    = src_bytes[src_idx & 15];
    conf_done = (rise_cnt >= cd_rise_thr) || (src_idx >= cd_byte_thr);
    n_status  = !(rise_cnt >= ns_rise_thr);
  end

  // Starter model: idle-ready, drops ready on the pulse, answers after st_delay cycles.
  always @(negedge clock) begin
    if (starter_start) begin
      starter_ready = 1'b0;
      starter_error = 1'b0;
      st_cnt        = st_delay;
    end else if (st_cnt > 0) begin
      st_cnt--;
      if (st_cnt == 0) begin
        if (st_fail) starter_error = 1'b1;
        else starter_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected data0 at rise k: LSB-first bits of consumed bytes, then zeros for init clocks.
  function automatic int bits_err(input int consumed);
    int   e;
    logic exp_b;
    e = 0;
    for (int k = 0; k < rise_bits.size(); k++) begin
      if (k < 8 * consumed) exp_b = src_bytes[k / 8][k % 8];
      else exp_b = 1'b0;
      if (rise_bits[k] !== exp_b) e++;
    end
    return e;
  endfunction

  task automatic setup(input int n, input bit rnd);
    @(negedge clock); #1;
    for (int i = 0; i < 16; i++) src_bytes[i] = rnd ? 8'($urandom) : 8'h00;
    src_n = n; src_idx = 0; rise_cnt = 0; sr_cnt = 0; ss_cnt = 0; stall_viol = 0;
    rise_bits.delete();
    cd_rise_thr = Never; cd_byte_thr = Never; ns_rise_thr = Never;
    stall_from = 0; stall_to = 0; stall_chk_lo = 0;
    st_fail = 1'b0; st_delay = 5;
  endtask

  task automatic do_start(input int len);
    @(negedge clock); #1;
    length = 32'(len);
    start  = 1'b1;
    @(negedge clock); #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock); #1;
    while (busy && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int n, len;
    reset = 1'b1; start = 1'b0; length = '0;
    starter_ready = 1'b1; starter_error = 1'b0;
    s_valid = 1'b0; s_data = '0; n_status = 1'b1; conf_done = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_outs", {dclk, data0, s_ready, starter_start, busy, done, error, err_code}, '0);
    reset = 1'b0;

    // Nominal load of A5 3C FF, CONF_DONE after the last data edge.
    setup(3, 1'b0);
    src_bytes[0] = 8'hA5; src_bytes[1] = 8'h3C; src_bytes[2] = 8'hFF;
    cd_rise_thr = 24;
    do_start(3);
    wait_idle("t1_timeout");
    chk("t1_rises", rise_cnt, 24 + INIT_CLOCKS);
    chk("t1_bits", bits_err(3), 0);
    chk("t1_done_err", {done, error, err_code}, {1'b1, 1'b0, 2'd0});
    chk("t1_pulse", ss_cnt, 1);
    chk("t1_bytes", src_idx, 3);

    // Starter failure.
    setup(2, 1'b1);
    st_fail = 1'b1;
    do_start(2);
    wait_idle("t2_timeout");
    chk("t2_err", {done, error, err_code}, {1'b0, 1'b1, 2'd1});
    chk("t2_rises", rise_cnt, 0);
    chk("t2_sready", sr_cnt, 0);

    // Missing CONF_DONE.
    setup(2, 1'b1);
    do_start(2);
    wait_idle("t3_timeout");
    chk("t3_err", {done, error, err_code}, {1'b0, 1'b1, 2'd2});
    chk("t3_rises", rise_cnt, 16);
    chk("t3_bits", bits_err(2), 0);

    // nSTATUS drops during byte 2, bit 3 (after its rising edge).
    setup(3, 1'b1);
    ns_rise_thr = 12;
    do_start(3);
    n = 0;
    while (n_status && n < 1000) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t4_drop_seen", n_status, 1'b0);
    repeat (SYNC_STAGES + 1) @(posedge clock);
    @(negedge clock); #1;
    chk("t4_react", {dclk, error, err_code}, {1'b0, 1'b1, 2'd3});
    repeat (20) @(negedge clock);
    #1;
    chk("t4_rises", rise_cnt, 12);
    chk("t4_sready", sr_cnt, 2);
    chk("t4_bits", bits_err(2), 0);
    ns_rise_thr = Never;

    // Stall mid-stream, then CONF_DONE early after byte 2 of 4.
    setup(4, 1'b1);
    cd_byte_thr = 2;
    do_start(4);
    n = 0;
    while (src_idx < 1 && n < 1000) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t5_first_byte", src_idx, 1);
    stall_from = cyc; stall_to = cyc + 52; stall_chk_lo = cyc + 33;
    wait_idle("t5_timeout");
    chk("t5_stall_dclk", stall_viol, 0);
    chk("t5_bytes", src_idx, 2);
    chk("t5_rises", rise_cnt, 16 + INIT_CLOCKS);
    chk("t5_bits", bits_err(2), 0);
    chk("t5_done", {done, error, err_code}, {1'b1, 1'b0, 2'd0});

    // Reset during a high phase, then zero-length runs.
    setup(3, 1'b1);
    do_start(3);
    n = 0;
    while (!dclk && n < 1000) begin
      @(negedge clock); #1;
      n++;
    end
    chk("t6_in_high", dclk, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_reset_outs", {dclk, data0, s_ready, starter_start, busy, done, error, err_code}, '0);
    @(negedge clock); #1;
    reset = 1'b0;
    setup(0, 1'b0);
    cd_rise_thr = 0;
    do_start(0);
    wait_idle("t6a_timeout");
    chk("t6a_done", {done, error, err_code}, {1'b1, 1'b0, 2'd0});
    chk("t6a_rises", rise_cnt, INIT_CLOCKS);
    chk("t6a_sready", sr_cnt, 0);
    setup(0, 1'b0);
    do_start(0);
    wait_idle("t6b_timeout");
    chk("t6b_err", {done, error, err_code}, {1'b0, 1'b1, 2'd2});
    chk("t6b_rises", rise_cnt, 0);

    // Random lengths and data with nominal CONF_DONE timing.
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(1, 4));
      setup(len, 1'b1);
      cd_rise_thr = 8 * len;
      st_delay = int'($urandom_range(1, 8));
      do_start(len);
      wait_idle("rnd_timeout");
      chk("rnd_done", {done, error, err_code}, {1'b1, 1'b0, 2'd0});
      chk("rnd_rises", rise_cnt, 8 * len + INIT_CLOCKS);
      chk("rnd_bits", bits_err(len), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps_loader.md
Name: ps_loader

Overview:
- Sequences a full Cyclone IV E passive-serial configuration of the target FPGA.
- Triggers the existing nCONFIG starter block and waits for its ready/error result.
- Streams a bitstream of `length` bytes from a valid/ready byte source onto DCLK/DATA0, LSB first.
- Checks CONF_DONE, then issues the initialization clocks. Sits between the bitstream source (flash reader or host FIFO) and the starter plus configuration pins.

Parameters:
- CLK_DIV, 2: system clocks per DCLK half-period (>=1). Bit period = 2*CLK_DIV clocks.
- INIT_CLOCKS, 3192: DCLK pulses issued after CONF_DONE is seen high (>=1).
- SYNC_STAGES, 2: flip-flop stages on n_status and conf_done.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin configuration (level sampled in IDLE/DONE/ERROR)
- length  in  32  bitstream size in bytes, latched on accepted start
- busy  out  1  high in any state other than IDLE/DONE/ERROR
- done  out  1  sticky success flag
- error  out  1  sticky failure flag
- err_code  out  2  0 none, 1 starter error, 2 CONF_DONE missing, 3 nSTATUS low
- starter_start  out  1  one-cycle pulse to starter
- starter_ready  in  1  starter idle/success
- starter_error  in  1  starter failure
- s_data  in  8  bitstream byte
- s_valid  in  1  byte available
- s_ready  out  1  byte accepted when s_valid && s_ready
- dclk  out  1  configuration clock to FPGA
- data0  out  1  configuration data to FPGA
- n_status  in  1  FPGA nSTATUS, asynchronous
- conf_done  in  1  FPGA CONF_DONE, asynchronous

Behaviour:
- Reset values: every output 0 (dclk=0, data0=0, s_ready=0, starter_start=0, busy=0, done=0, error=0, err_code=0). State returns to IDLE. All counters clear. Reset mid-transfer aborts immediately, leaving no partial flags.
- n_status and conf_done pass through SYNC_STAGES flops. All decisions use the synchronized values, "ns_s"/"cd_s".

States:
- IDLE / DONE / ERROR:
  - start=1 clears done, error and err_code, latches length, and goes to KICK.
  - start while busy is ignored.
- KICK: starter_start=1 for exactly one cycle -> ARM.
- ARM: one cycle, letting the starter leave its idle state -> WAIT_ST.
- WAIT_ST:
  - starter_error=1 -> ERROR, err_code=1.
  - Otherwise starter_ready=1 -> LOAD, or CHECK if the latched length = 0.
- LOAD:
  - s_ready=1. On s_valid, capture s_data into the shift register, decrement the remaining count, bit index=0 -> SHIFT_LO.
  - s_ready is combinational (state==LOAD), so at most one byte is accepted per visit.
- SHIFT_LO: dclk=0, data0=shreg[bit] for CLK_DIV clocks -> SHIFT_HI.
- SHIFT_HI:
  - dclk=1 for CLK_DIV clocks; data0 holds (stable across the rising edge).
  - Then, if bit<7: bit+1 -> SHIFT_LO.
  - Otherwise, if bytes remain -> LOAD, else -> CHECK.
- CHECK:
  - dclk=0 for SYNC_STAGES+2 clocks, then sample cd_s.
  - cd_s=1 -> INIT. cd_s=0 -> ERROR, err_code=2.
- INIT: INIT_CLOCKS full DCLK periods (low CLK_DIV, high CLK_DIV), data0=0 -> DONE with done=1.
- nSTATUS check: ns_s=0 observed in LOAD, SHIFT_LO, SHIFT_HI, CHECK or INIT -> ERROR, err_code=3, dclk forced to 0 next cycle. This check takes priority over every other transition.
- Early CONF_DONE: cd_s=1 on entry to LOAD with bytes remaining -> CHECK. Remaining bytes are not consumed and no error is raised.
- Data stall: s_valid low in LOAD holds dclk=0 indefinitely, with no timeout.
- Outputs are registered except s_ready. dclk has no glitches. data0 changes only while dclk=0.
- Throughput with s_valid always high: 1 LOAD clock + 16*CLK_DIV clocks per byte.

Test Plan (CLK_DIV=2, INIT_CLOCKS=8, SYNC_STAGES=2):
1. Nominal load:
   - Stimulus: length=3, bytes 0xA5,0x3C,0xFF; starter model asserts ready 5 cycles after the pulse; conf_done rises after the 24th dclk rising edge.
   - Required: data0 at the rising edges = 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / 1×8; exactly 24+8 dclk rising edges; done=1, err_code=0; starter_start high exactly 1 cycle.
2. Starter failure:
   - Stimulus: starter_error=1 after the pulse.
   - Required: error=1, err_code=1, zero dclk edges, s_ready never high.
3. Missing CONF_DONE:
   - Stimulus: length=2, conf_done held 0.
   - Required: after 16 dclk rising edges, error=1, err_code=2, no INIT clocks.
4. nSTATUS drop:
   - Stimulus: n_status pulled low during byte 2, bit 3.
   - Required: within SYNC_STAGES+1 clocks dclk=0 and err_code=3; no further s_ready.
5. Stall and early CONF_DONE:
   - Stimulus: s_valid low for 20 clocks mid-stream, where dclk must stay 0; then conf_done=1 after byte 2 of length=4.
   - Required: only 2 bytes consumed, 8 INIT clocks, done=1.
6. Reset and restart:
   - Stimulus: reset asserted mid-SHIFT_HI.
   - Required: all outputs 0 the same cycle. A fresh start with length=0 goes to CHECK, reaching done (cd_s=1) or err_code=2 (cd_s=0).
